// File: rtl/vpe_issue_scheduler.sv
// rtl/vpe_issue_scheduler.sv - round-robin burst scheduler sharing one VPE between pipe-stage requesters
//
// Purpose: grants the VPE to one requester at a time for a bounded burst,
// locks the VPE mode for that burst, drains the VPE before the next owner,
// and routes results back as per-requester strobes after LAT cycles.
//
// Ports:
//   CLK_i        clock, rising edge
//   RST_i        synchronous reset, active-low
//   req_i        per-requester op ready
//   req_mode_i   per-requester VPE mode, sampled at grant
//   req_last_i   per-requester last-op-of-burst marker
//   gnt_o        one-hot (or zero) ownership, registered
//   vpe_valid_o  VPE operands valid (registered, one cycle after handshake)
//   vpe_mode_o   locked VPE mode
//   vpe_owner_o  current or last owner index
//   rsp_valid_o  per-requester result strobe
//   busy_o       not idle, or results still in flight
module vpe_issue_scheduler #(
    parameter int N_REQ     = 3,
    parameter int MODE_W    = 4,
    parameter int LAT       = 4,
    parameter int MAX_BURST = 8,
    localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      CLK_i,
    input  logic                      RST_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*MODE_W-1:0]   req_mode_i,
    input  logic [N_REQ-1:0]          req_last_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic                      vpe_valid_o,
    output logic [MODE_W-1:0]         vpe_mode_o,
    output logic [OW-1:0]             vpe_owner_o,
    output logic [N_REQ-1:0]          rsp_valid_o,
    output logic                      busy_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int DW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [OW-1:0]            owner_q, owner_d;
    logic [OW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [MODE_W-1:0]        mode_q, mode_d;
    logic [BW-1:0]            burst_cnt_q, burst_cnt_d;
    logic [DW-1:0]            drain_cnt_q, drain_cnt_d;
    logic [N_REQ-1:0]         gnt_q, gnt_d;
    logic                     vpe_valid_q, vpe_valid_d;
    logic [LAT-1:0]           pipe_v_q, pipe_v_d;
    logic [LAT-1:0][OW-1:0]   pipe_o_q, pipe_o_d;

    logic                     found;
    logic [OW-1:0]            win;
    int                       idx;
    logic                     release_now;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        mode_d      = mode_q;
        burst_cnt_d = burst_cnt_q;
        drain_cnt_d = drain_cnt_q;
        gnt_d       = gnt_q;
        vpe_valid_d = 1'b0;
        release_now = 1'b0;
        found       = 1'b0;
        win         = '0;
        idx         = 0;

        // Round-robin scan starting at rr_ptr; first requester found wins.
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % N_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end

        // Results follow the issuing owner down the latency pipe.
        pipe_v_d[0] = vpe_valid_q;
        pipe_o_d[0] = owner_q;
        for (int i = 1; i < LAT; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_o_d[i] = pipe_o_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d     = win;
                    mode_d      = req_mode_i[win*MODE_W +: MODE_W];
                    burst_cnt_d = '0;
                    gnt_d       = N_REQ'(1) << win;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!req_i[owner_q]) begin
                    // Owner has nothing left to issue: yield early.
                    release_now = 1'b1;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    vpe_valid_d = 1'b1;
                    if (req_last_i[owner_q] || (burst_cnt_q == BW'(MAX_BURST - 1))) begin
                        release_now = 1'b1;
                    end
                end
                if (release_now) begin
                    gnt_d       = '0;
                    rr_ptr_d    = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    drain_cnt_d = DW'(LAT);
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q - 1'b1;
                if (drain_cnt_q == DW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_i) begin
        if (!RST_i) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            mode_q      <= '0;
            burst_cnt_q <= '0;
            drain_cnt_q <= '0;
            gnt_q       <= '0;
            vpe_valid_q <= 1'b0;
            pipe_v_q    <= '0;
            pipe_o_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            mode_q      <= mode_d;
            burst_cnt_q <= burst_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            gnt_q       <= gnt_d;
            vpe_valid_q <= vpe_valid_d;
            pipe_v_q    <= pipe_v_d;
            pipe_o_q    <= pipe_o_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign vpe_valid_o = vpe_valid_q;
    assign vpe_mode_o  = mode_q;
    assign vpe_owner_o = owner_q;
    assign rsp_valid_o = pipe_v_q[LAT-1] ? (N_REQ'(1) << pipe_o_q[LAT-1]) : '0;
    assign busy_o      = (state_q != S_IDLE) | vpe_valid_q | (|pipe_v_q);

endmodule

// File: tb/tb_vpe_issue_scheduler.sv
// tb/tb_vpe_issue_scheduler.sv - directed self-checking bench for vpe_issue_scheduler
module tb_vpe_issue_scheduler;

    logic        CLK_i;
    logic        RST_i;
    logic [2:0]  req_i;
    logic [11:0] req_mode_i;
    logic [2:0]  req_last_i;
    logic [2:0]  gnt_o;
    logic        vpe_valid_o;
    logic [3:0]  vpe_mode_o;
    logic [1:0]  vpe_owner_o;
    logic [2:0]  rsp_valid_o;
    logic        busy_o;

    int vectors;
    int miscompares;

    logic [2:0] gnt_h  [0:63];
    logic [3:0] mode_h [0:63];
    int hs_q[$];
    int vv_q[$];
    int vmode_q[$];
    int rsp_q[$];
    int rspv_q[$];
    int gq[$];
    int gstart[$];
    int rel[$];

    vpe_issue_scheduler dut (
        .CLK_i       (CLK_i),
        .RST_i       (RST_i),
        .req_i       (req_i),
        .req_mode_i  (req_mode_i),
        .req_last_i  (req_last_i),
        .gnt_o       (gnt_o),
        .vpe_valid_o (vpe_valid_o),
        .vpe_mode_o  (vpe_mode_o),
        .vpe_owner_o (vpe_owner_o),
        .rsp_valid_o (rsp_valid_o),
        .busy_o      (busy_o)
    );

    initial CLK_i = 1'b0;
    always #5 CLK_i = ~CLK_i;

    task automatic tick;
        @(posedge CLK_i);
        #1;
    endtask

    task automatic do_reset;
        RST_i      = 1'b0;
        req_i      = '0;
        req_last_i = '0;
        req_mode_i = '0;
        tick();
        tick();
        RST_i = 1'b1;
        hs_q.delete(); vv_q.delete(); vmode_q.delete(); rsp_q.delete();
        rspv_q.delete(); gq.delete(); gstart.delete(); rel.delete();
    endtask

    task automatic test_reset;
        RST_i      = 1'b0;
        req_i      = 3'b111;
        req_last_i = 3'b000;
        req_mode_i = 12'h321;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if ({gnt_o, vpe_valid_o, vpe_mode_o, vpe_owner_o, rsp_valid_o, busy_o} !== 14'd0) begin
                $display("FAIL reset_outputs cycle %0d: got gnt=%b vv=%b mode=%h own=%0d rsp=%b busy=%b, want all 0",
                         c, gnt_o, vpe_valid_o, vpe_mode_o, vpe_owner_o, rsp_valid_o, busy_o);
                miscompares++;
            end
        end
        RST_i = 1'b1;
        tick();
        vectors++;
        if (gnt_o !== 3'b001) begin
            $display("FAIL reset_first_grant: got %b want 001", gnt_o);
            miscompares++;
        end
        vectors++;
        if (vpe_mode_o !== 4'h1 || vpe_owner_o !== 2'd0) begin
            $display("FAIL reset_first_mode: got mode=%h own=%0d want mode=1 own=0", vpe_mode_o, vpe_owner_o);
            miscompares++;
        end
    endtask

    task automatic test_single_burst;
        int ops;
        do_reset();
        req_mode_i[7:4] = 4'h5;
        ops = 0;
        for (int n = 0; n < 30; n++) begin
            if (vpe_valid_o) begin vv_q.push_back(n); vmode_q.push_back(int'(vpe_mode_o)); end
            if (rsp_valid_o != 3'b000) begin rsp_q.push_back(n); rspv_q.push_back(int'(rsp_valid_o)); end
            gnt_h[n]   = gnt_o;
            req_i      = (ops < 3) ? 3'b010 : 3'b000;
            req_last_i = (ops == 2) ? 3'b010 : 3'b000;
            if (gnt_o[1] && req_i[1]) begin hs_q.push_back(n); ops++; end
            tick();
        end
        vectors++;
        if (hs_q.size() != 3 || vv_q.size() != 3 || rsp_q.size() != 3) begin
            $display("FAIL single_counts: got hs=%0d vv=%0d rsp=%0d want 3 3 3", hs_q.size(), vv_q.size(), rsp_q.size());
            miscompares++;
        end else begin
            vectors++;
            if (hs_q[0] != 1 || hs_q[1] != 2 || hs_q[2] != 3) begin
                $display("FAIL single_hs_cycles: got %0d %0d %0d want 1 2 3", hs_q[0], hs_q[1], hs_q[2]);
                miscompares++;
            end
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (vv_q[i] != hs_q[i] + 1 || vmode_q[i] != 5) begin
                    $display("FAIL single_vpe_valid[%0d]: got cyc=%0d mode=%0d want cyc=%0d mode=5",
                             i, vv_q[i], vmode_q[i], hs_q[i] + 1);
                    miscompares++;
                end
                vectors++;
                if (rsp_q[i] != hs_q[i] + 5 || rspv_q[i] != 2) begin
                    $display("FAIL single_rsp[%0d]: got cyc=%0d val=%0d want cyc=%0d val=2",
                             i, rsp_q[i], rspv_q[i], hs_q[i] + 5);
                    miscompares++;
                end
            end
            vectors++;
            if (gnt_h[hs_q[2]] !== 3'b010 || gnt_h[hs_q[2] + 1] !== 3'b000) begin
                $display("FAIL single_gnt_drop: got %b then %b want 010 then 000", gnt_h[hs_q[2]], gnt_h[hs_q[2] + 1]);
                miscompares++;
            end
        end
    endtask

    task automatic test_max_burst;
        do_reset();
        req_i      = 3'b001;
        req_last_i = 3'b000;
        for (int n = 0; n < 21; n++) begin
            gnt_h[n] = gnt_o;
            if (gnt_o[0] && req_i[0]) hs_q.push_back(n);
            tick();
        end
        vectors++;
        if (hs_q.size() != 15) begin
            $display("FAIL max_hs_count: got %0d want 15", hs_q.size());
            miscompares++;
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (hs_q[i] != i + 1) begin
                    $display("FAIL max_hs[%0d]: got cyc=%0d want %0d", i, hs_q[i], i + 1);
                    miscompares++;
                end
            end
            vectors++;
            if (hs_q[8] != 14) begin
                $display("FAIL max_regrant_hs: got cyc=%0d want 14", hs_q[8]);
                miscompares++;
            end
        end
        for (int n = 9; n <= 13; n++) begin
            vectors++;
            if (gnt_h[n] !== 3'b000) begin
                $display("FAIL max_drain_gnt cyc %0d: got %b want 000", n, gnt_h[n]);
                miscompares++;
            end
        end
        vectors++;
        if (gnt_h[14] !== 3'b001) begin
            $display("FAIL max_regrant: got %b want 001", gnt_h[14]);
            miscompares++;
        end
    endtask

    task automatic test_round_robin;
        int bc;
        int overlap;
        int vv;
        logic [2:0] prev;
        do_reset();
        req_i   = 3'b111;
        bc      = 0;
        overlap = 0;
        vv      = 0;
        prev    = 3'b000;
        for (int n = 0; n < 25; n++) begin
            if (!$onehot0(gnt_o)) overlap++;
            if (vpe_valid_o) vv++;
            if (gnt_o != 3'b000 && prev == 3'b000) begin gq.push_back(int'(gnt_o)); gstart.push_back(n); end
            prev = gnt_o;
            if (gnt_o == 3'b000) bc = 0;
            req_last_i = (bc == 1) ? 3'b111 : 3'b000;
            if ((gnt_o & req_i) != 3'b000) begin
                hs_q.push_back(n);
                if (bc == 1) rel.push_back(n);
                bc++;
            end
            tick();
        end
        vectors++;
        if (gq.size() != 4) begin
            $display("FAIL rr_grant_count: got %0d want 4", gq.size());
            miscompares++;
        end else begin
            vectors++;
            if (gq[0] != 1 || gq[1] != 2 || gq[2] != 4 || gq[3] != 1) begin
                $display("FAIL rr_order: got %0d %0d %0d %0d want 1 2 4 1", gq[0], gq[1], gq[2], gq[3]);
                miscompares++;
            end
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (i >= rel.size() || gstart[i+1] - rel[i] != 6) begin
                    $display("FAIL rr_drain_gap[%0d]: got gap=%0d want 6", i,
                             (i < rel.size()) ? gstart[i+1] - rel[i] : -1);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (overlap != 0) begin
            $display("FAIL rr_overlap: got %0d non-onehot cycles want 0", overlap);
            miscompares++;
        end
        vectors++;
        if (hs_q.size() != 8 || vv != 8) begin
            $display("FAIL rr_ops: got hs=%0d vv=%0d want 8 8", hs_q.size(), vv);
            miscompares++;
        end
    endtask

    task automatic test_mode_lock;
        int ops;
        do_reset();
        req_mode_i[3:0] = 4'h2;
        req_i           = 3'b001;
        ops             = 0;
        for (int n = 0; n < 21; n++) begin
            mode_h[n] = vpe_mode_o;
            gnt_h[n]  = gnt_o;
            if (ops >= 1) req_mode_i[3:0] = 4'h7;
            req_last_i = (ops == 3) ? 3'b001 : 3'b000;
            if (gnt_o[0] && req_i[0]) ops++;
            tick();
        end
        for (int n = 1; n <= 9; n++) begin
            vectors++;
            if (mode_h[n] !== 4'h2) begin
                $display("FAIL mode_lock cyc %0d: got %h want 2", n, mode_h[n]);
                miscompares++;
            end
        end
        vectors++;
        if (gnt_h[5] !== 3'b000 || gnt_h[10] !== 3'b001 || mode_h[10] !== 4'h7) begin
            $display("FAIL mode_regrant: got gnt5=%b gnt10=%b mode10=%h want 000 001 7",
                     gnt_h[5], gnt_h[10], mode_h[10]);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid;
        int rsp_seen;
        do_reset();
        req_i      = 3'b001;
        req_last_i = 3'b000;
        tick();
        tick();
        tick();
        vectors++;
        if (vpe_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            $display("FAIL mid_inflight: got vv=%b busy=%b want 1 1", vpe_valid_o, busy_o);
            miscompares++;
        end
        RST_i = 1'b0;
        req_i = 3'b000;
        tick();
        vectors++;
        if ({gnt_o, vpe_valid_o, vpe_mode_o, vpe_owner_o, rsp_valid_o, busy_o} !== 14'd0) begin
            $display("FAIL mid_reset_outputs: got gnt=%b vv=%b rsp=%b busy=%b want all 0",
                     gnt_o, vpe_valid_o, rsp_valid_o, busy_o);
            miscompares++;
        end
        RST_i    = 1'b1;
        rsp_seen = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (rsp_valid_o != 3'b000 || busy_o) rsp_seen++;
        end
        vectors++;
        if (rsp_seen != 0) begin
            $display("FAIL mid_no_rsp: got %0d cycles with rsp/busy want 0", rsp_seen);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST_i       = 1'b0;
        req_i       = '0;
        req_last_i  = '0;
        req_mode_i  = '0;
        test_reset();
        test_single_burst();
        test_max_burst();
        test_round_robin();
        test_mode_lock();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
